// File: rtl/uart_core_cfg.sv
// uart_core_cfg: configurable full-duplex UART (5..8 data bits, optional parity, 1/2 stop bits, oversampled RX)
module uart_core_cfg #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int DIV      = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int BIT_CLKS = DIV * OVERSAMPLE;
  localparam int TCW      = $clog2(BIT_CLKS * STOP_BITS + 1);
  localparam int DCW      = $clog2(DIV + 1);
  localparam int KCW      = $clog2(OVERSAMPLE + 1);
  localparam int BCW      = $clog2(DATA_BITS + 1);
  localparam logic [TCW-1:0] BIT_LAST  = TCW'(BIT_CLKS - 1);
  localparam logic [TCW-1:0] STOP_LAST = TCW'(BIT_CLKS * STOP_BITS - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [KCW-1:0] HALF_LAST = KCW'(OVERSAMPLE / 2 - 1);
  localparam logic [KCW-1:0] OS_LAST   = KCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] DB_LAST   = BCW'(DATA_BITS - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4, S_BRK = 3'd5;
  localparam logic [2:0] S_AFTER_DATA = (PARITY_EN != 0) ? S_PAR : S_STOP;
  localparam logic       ODD = (PARITY_ODD != 0);

  logic [2:0]           tx_st_q, tx_st_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BCW-1:0]       tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d, tx_done_q, tx_done_d;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q + 1'b1;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_done_d = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (tx_start) begin
          tx_st_d  = S_START;
          tx_sh_d  = tx_data;
          tx_par_d = (^tx_data) ^ ODD;
        end
      end
      S_START: if (tx_cnt_q == BIT_LAST) begin
        tx_st_d  = S_DATA;
        tx_cnt_d = '0;
        tx_bit_d = '0;
      end
      S_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == DB_LAST) tx_st_d = S_AFTER_DATA;
      end
      S_PAR: if (tx_cnt_q == BIT_LAST) begin
        tx_st_d  = S_STOP;
        tx_cnt_d = '0;
      end
      default: if (tx_cnt_q == STOP_LAST) begin
        tx_st_d   = S_IDLE;
        tx_done_d = 1'b1;
      end
    endcase
  end

  assign tx      = tx_st_q == S_START ? 1'b0 : tx_st_q == S_DATA ? tx_sh_q[0] : tx_st_q == S_PAR ? tx_par_q : 1'b1;
  assign tx_busy = tx_st_q != S_IDLE;
  assign tx_done = tx_done_q;

  logic                 rx_m_q, rx_s_q, tick, done, clr;
  logic [DCW-1:0]       div_q, div_d;
  logic [2:0]           rx_st_q, rx_st_d;
  logic [KCW-1:0]       rx_tk_q, rx_tk_d;
  logic [BCW-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                 rx_pb_q, rx_pb_d, rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d;

  assign tick  = div_q == DIV_LAST;
  assign div_d = tick ? '0 : div_q + 1'b1;
  assign clr   = rx_ack & rx_valid_q;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_tk_d  = rx_tk_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_pb_d  = rx_pb_q;
    done     = 1'b0;
    if (tick) begin
      rx_tk_d = rx_tk_q + 1'b1;
      case (rx_st_q)
        S_IDLE: if (!rx_s_q) begin
          rx_st_d = S_START;
          rx_tk_d = '0;
        end
        S_START: if (rx_tk_q == HALF_LAST) begin
          rx_st_d  = rx_s_q ? S_IDLE : S_DATA;
          rx_tk_d  = '0;
          rx_bit_d = '0;
        end
        S_DATA: if (rx_tk_q == OS_LAST) begin
          rx_tk_d  = '0;
          rx_sh_d  = {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == DB_LAST) rx_st_d = S_AFTER_DATA;
        end
        S_PAR: if (rx_tk_q == OS_LAST) begin
          rx_tk_d = '0;
          rx_pb_d = rx_s_q;
          rx_st_d = S_STOP;
        end
        S_STOP: if (rx_tk_q == OS_LAST) begin
          done    = 1'b1;
          rx_st_d = rx_s_q ? S_IDLE : S_BRK;
        end
        default: if (rx_s_q) rx_st_d = S_IDLE;
      endcase
    end
  end

  // a completing frame always wins over a same-cycle acknowledge
  assign rx_data_d  = done ? rx_sh_q : rx_data_q;
  assign rx_valid_d = done | (rx_valid_q & ~rx_ack);
  assign rx_perr_d  = done ? (PARITY_EN != 0) & (rx_pb_q != ((^rx_sh_q) ^ ODD)) : rx_perr_q & ~clr;
  assign rx_ferr_d  = done ? ~rx_s_q : rx_ferr_q & ~clr;
  assign rx_ovr_d   = (rx_ovr_q & ~clr) | (done & rx_valid_q & ~rx_ack);

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_st_q    <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      div_q      <= '0;
      rx_st_q    <= S_IDLE;
      rx_tk_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pb_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_done_q  <= tx_done_d;
      rx_m_q     <= rx;
      rx_s_q     <= rx_m_q;
      div_q      <= div_d;
      rx_st_q    <= rx_st_d;
      rx_tk_q    <= rx_tk_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pb_q    <= rx_pb_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
endmodule
